sum_capture_reg: RTL and testbench



---
 rtl/sum_capture_reg.sv | 155 +++++++++++++++
 tb/tb_sum_capture_reg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_capture_reg.sv
// sum_capture_reg: collects an N-bit serial adder result into a parallel word and holds it for a consumer.
// Optional final-carry capture is enabled by defining SUM_CAPTURE_CARRY_EN (adds w_carry / o_carry).
module sum_capture_reg #(
    parameter int N   = 8,
    parameter int DIR = 0
) (
    input  logic         i_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] s_in,
    input  logic         start,
    input  logic         w3,
    input  logic         bit_vld,
    input  logic         i_ready,
`ifdef SUM_CAPTURE_CARRY_EN
    input  logic         w_carry,
    output logic         o_carry,
`endif
    output logic [N-1:0] s_out,
    output logic         busy,
    output logic         done,
    output logic         o_valid
);

    // state | meaning
    // IDLE  | waiting for start; load may preload s_out
    // SHIFT | accepting serial bits on bit_vld
    // HOLD  | complete word presented until i_ready
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  s_out_q, s_out_d;
    logic [N-1:0]  shifted;
    logic          done_q, done_d;
    logic          last_bit;

    assign last_bit = (state_q == ST_SHIFT) && bit_vld && (cnt_q == LAST);

    // Shifting toward the far end keeps the first-arriving bit in its true position.
    always_comb begin
        shifted = s_out_q;
        if (DIR == 0) begin
            shifted = {w3, s_out_q[N-1:1]};
        end else begin
            shifted = {s_out_q[N-2:0], w3};
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_SHIFT);
        o_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        cnt_d   = cnt_q;
        s_out_d = s_out_q;
        done_d  = last_bit;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                end else if (load) begin
                    s_out_d = s_in;
                end
            end
            ST_SHIFT: begin
                if (bit_vld) begin
                    s_out_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = cnt_q;
                s_out_d = s_out_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            cnt_q   <= '0;
            s_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            s_out_q <= s_out_d;
            done_q  <= done_d;
        end
    end

    assign s_out = s_out_q;
    assign done  = done_q;

`ifdef SUM_CAPTURE_CARRY_EN
    logic carry_q, carry_d;

    always_comb begin
        carry_d = carry_q;
        if ((state_q == ST_IDLE) && start) begin
            carry_d = 1'b0;
        end else if (last_bit) begin
            carry_d = w_carry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign o_carry = carry_q;
`endif

endmodule

// File: tb/tb_sum_capture_reg.sv
// Directed bench for sum_capture_reg: an N=8 LSB-first instance and an N=16 MSB-first instance.
module tb_sum_capture_reg;

    logic        i_clk = 1'b0;
    logic        reset = 1'b1;

    logic        load = 1'b0, start = 1'b0, w3 = 1'b0, bit_vld = 1'b0, i_ready = 1'b0;
    logic [7:0]  s_in = 8'h00;
    logic [7:0]  s_out;
    logic        busy, done, o_valid;

    logic        load16 = 1'b0, start16 = 1'b0, w3_16 = 1'b0, bit_vld16 = 1'b0, i_ready16 = 1'b0;
    logic [15:0] s_in16 = 16'h0000;
    logic [15:0] s_out16;
    logic        busy16, done16, o_valid16;
`ifdef SUM_CAPTURE_CARRY_EN
    logic        w_carry = 1'b0;
    logic        o_carry;
    logic        w_carry8 = 1'b0;
    logic        o_carry8;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt;

    always #5 i_clk = ~i_clk;

    sum_capture_reg #(.N(8), .DIR(0)) u_dut (
        .i_clk   (i_clk),
        .reset   (reset),
        .load    (load),
        .s_in    (s_in),
        .start   (start),
        .w3      (w3),
        .bit_vld (bit_vld),
        .i_ready (i_ready),
`ifdef SUM_CAPTURE_CARRY_EN
        .w_carry (w_carry8),
        .o_carry (o_carry8),
`endif
        .s_out   (s_out),
        .busy    (busy),
        .done    (done),
        .o_valid (o_valid)
    );

    sum_capture_reg #(.N(16), .DIR(1)) u_dut16 (
        .i_clk   (i_clk),
        .reset   (reset),
        .load    (load16),
        .s_in    (s_in16),
        .start   (start16),
        .w3      (w3_16),
        .bit_vld (bit_vld16),
        .i_ready (i_ready16),
`ifdef SUM_CAPTURE_CARRY_EN
        .w_carry (w_carry),
        .o_carry (o_carry),
`endif
        .s_out   (s_out16),
        .busy    (busy16),
        .done    (done16),
        .o_valid (o_valid16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Starts a capture and feeds word LSB-first; gaps[i] idle cycles precede bit i.
    // Returns one cycle after the final accepted bit (done/o_valid expected high).
    task automatic send8(input logic [7:0] word, input logic [31:0] gaps);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < int'(gaps[i*4 +: 4]); g++) begin
                bit_vld = 1'b0;
                w3      = ~word[i];
                tick();
                check("gap_busy", busy, 1'b1);
                if (done) done_cnt++;
            end
            bit_vld = 1'b1;
            w3      = word[i];
            tick();
            if (done) done_cnt++;
            if (i < 7) check("shift_busy", busy, 1'b1);
        end
        bit_vld = 1'b0;
        w3      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_s_out", s_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_s_out16", s_out16, 16'h0000);
        reset = 1'b0;
        tick();

        // Back-to-back bits of 0xA5
        send8(8'hA5, 32'h0000_0000);
        check("a5_done", done, 1'b1);
        check("a5_valid", o_valid, 1'b1);
        check("a5_s_out", s_out, 8'hA5);
        check("a5_busy", busy, 1'b0);
        tick();
        check("a5_done_pulse", done, 1'b0);
        check("a5_valid_hold", o_valid, 1'b1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("a5_idle_valid", o_valid, 1'b0);
        check("a5_idle_busy", busy, 1'b0);
        check("a5_kept", s_out, 8'hA5);

        // Same word with 0..3 cycle gaps between bits
        send8(8'hA5, 32'h3210_3210);
        check("gap_s_out", s_out, 8'hA5);
        check("gap_valid", o_valid, 1'b1);
        tick();
        if (done) done_cnt++;
        tick();
        if (done) done_cnt++;
        check("gap_done_once", done_cnt, 1);

        // HOLD ignores serial/control inputs while i_ready is low
        for (int c = 0; c < 5; c++) begin
            w3      = c[0];
            bit_vld = ~c[0];
            start   = c[0];
            load    = 1'b1;
            s_in    = 8'hFF;
            tick();
            check("hold_s_out", s_out, 8'hA5);
            check("hold_valid", o_valid, 1'b1);
        end
        w3 = 1'b0; bit_vld = 1'b0; start = 1'b0; load = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("hold_exit_valid", o_valid, 1'b0);
        check("hold_exit_busy", busy, 1'b0);

        // Reset mid-shift discards the partial word
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_vld = 1'b1;
            w3      = 1'b1;
            tick();
        end
        bit_vld = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        check("mid_rst_s_out", s_out, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", o_valid, 1'b0);
        send8(8'h3C, 32'h0000_0000);
        check("post_rst_s_out", s_out, 8'h3C);
        check("post_rst_done", done, 1'b1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // Preload in IDLE; start wins over load
        load = 1'b1;
        s_in = 8'h5A;
        tick();
        check("load_5a", s_out, 8'h5A);
        s_in = 8'h3C;
        tick();
        load = 1'b0;
        check("load_3c", s_out, 8'h3C);
        load  = 1'b1;
        s_in  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ls_busy", busy, 1'b1);
        check("ls_not_loaded", s_out, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            bit_vld = 1'b1;
            w3      = (i == 0) || (i == 7);
            tick();
        end
        bit_vld = 1'b0;
        load    = 1'b0;
        check("ls_s_out", s_out, 8'h81);
        check("ls_valid", o_valid, 1'b1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // N=16 MSB-first instance: 0xBEEF, carry on last bit
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hBEEF;
            bit_vld16 = 1'b1;
            w3_16     = w[15 - i];
`ifdef SUM_CAPTURE_CARRY_EN
            w_carry   = (i == 15);
`endif
            tick();
        end
        bit_vld16 = 1'b0;
`ifdef SUM_CAPTURE_CARRY_EN
        w_carry   = 1'b0;
`endif
        check("beef_s_out", s_out16, 16'hBEEF);
        check("beef_done", done16, 1'b1);
        check("beef_valid", o_valid16, 1'b1);
`ifdef SUM_CAPTURE_CARRY_EN
        check("beef_carry", o_carry, 1'b1);
        tick();
        check("beef_carry_hold", o_carry, 1'b1);
`endif
        i_ready16 = 1'b1;
        tick();
        i_ready16 = 1'b0;
        check("beef_idle", o_valid16, 1'b0);

        // Second 16-bit word 0x1234 without carry
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
`ifdef SUM_CAPTURE_CARRY_EN
        check("carry_clr_on_start", o_carry, 1'b0);
`endif
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h1234;
            bit_vld16 = 1'b1;
            w3_16     = w[15 - i];
            tick();
        end
        bit_vld16 = 1'b0;
        check("w1234_s_out", s_out16, 16'h1234);
        check("w1234_done", done16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
